// File: rtl/syscall_pkg.sv
// Shared types and constants for the console-input syscall responder.
package syscall_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIntLead,
    StIntDig,
    StChar,
    StDone
  } state_e;

  localparam int unsigned READ_INT_CODE_DEFAULT  = 5;
  localparam int unsigned READ_CHAR_CODE_DEFAULT = 12;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII decimal digit detector and value extractor.
module ascii_digit_decode
  import syscall_pkg::*;
#(
  parameter int unsigned CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] ch,
  output logic              is_digit,
  output logic [3:0]        value
);

  // Classify the byte and strip the ASCII '0' offset when it is a digit.
  always_comb begin
    is_digit = (ch >= CHAR_W'(ASCII_ZERO)) && (ch <= CHAR_W'(ASCII_NINE));
    value    = is_digit ? 4'(ch - CHAR_W'(ASCII_ZERO)) : 4'd0;
  end

endmodule

// File: rtl/syscall_reader.sv
// Syscall input responder: services read_int and read_char from a console byte stream,
// stalling the pipeline until a result is ready for $v0.
// Optional build macro: SYSCALL_READER_ECHO_EN adds an echo output stream of every
// accepted byte and gates InReady on EchoReady.
module syscall_reader
  import syscall_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CHAR_W         = 8,
  parameter int unsigned READ_INT_CODE  = READ_INT_CODE_DEFAULT,
  parameter int unsigned READ_CHAR_CODE = READ_CHAR_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Syscall,
  input  logic [WIDTH-1:0]  V0,
  input  logic              InValid,
  input  logic [CHAR_W-1:0] InData,
  output logic              InReady,
  output logic              StallReq,
  output logic              WbValid,
  output logic [WIDTH-1:0]  WbData,
`ifdef SYSCALL_READER_ECHO_EN
  output logic              Overflow,
  output logic              EchoValid,
  output logic [CHAR_W-1:0] EchoData,
  input  logic              EchoReady
`else
  output logic              Overflow
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic             neg_q;

  logic             trig_int;
  logic             trig_char;
  logic             busy;
  logic             xfer;
  logic             is_digit;
  logic [3:0]       dig_val;
  logic             is_blank;
  logic             is_nl;
  logic             is_minus;
  logic [WIDTH+3:0] mac;
  logic [WIDTH-1:0] int_result;

  ascii_digit_decode #(
    .CHAR_W (CHAR_W)
  ) u_digit (
    .ch       (InData),
    .is_digit (is_digit),
    .value    (dig_val)
  );

  // Trigger decode, stall request and input handshake.
  always_comb begin
    trig_int  = Syscall && (V0 == WIDTH'(READ_INT_CODE));
    trig_char = Syscall && (V0 == WIDTH'(READ_CHAR_CODE));
    busy      = (state_q == StIntLead) || (state_q == StIntDig) || (state_q == StChar);
    StallReq  = busy || ((state_q == StIdle) && (trig_int || trig_char));
`ifdef SYSCALL_READER_ECHO_EN
    InReady   = busy && EchoReady;
`else
    InReady   = busy;
`endif
    xfer      = InValid && InReady;
  end

`ifdef SYSCALL_READER_ECHO_EN
  // Echo mirrors every transfer, including bytes the parser throws away.
  always_comb begin
    EchoValid = xfer;
    EchoData  = InData;
  end
`endif

  // Byte classification and the decimal accumulate step (4 guard bits catch overflow).
  always_comb begin
    is_blank   = (InData == CHAR_W'(ASCII_SP)) || (InData == CHAR_W'(ASCII_TAB));
    is_nl      = (InData == CHAR_W'(ASCII_NL));
    is_minus   = (InData == CHAR_W'(ASCII_MINUS));
    mac        = ({4'b0000, acc_q} * (WIDTH + 4)'(10)) + (WIDTH + 4)'(dig_val);
    int_result = neg_q ? (WIDTH'(0) - acc_q) : acc_q;
  end

  // Main FSM with registered result, strobe and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      WbValid  <= 1'b0;
      WbData   <= '0;
      Overflow <= 1'b0;
    end else begin
      WbValid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig_int) begin
            state_q  <= StIntLead;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            Overflow <= 1'b0;
          end else if (trig_char) begin
            state_q <= StChar;
          end
        end
        StIntLead: begin
          // Blanks and unrecognised bytes are consumed without effect.
          if (xfer && !is_blank) begin
            if (is_minus) begin
              neg_q   <= 1'b1;
              state_q <= StIntDig;
            end else if (is_digit) begin
              acc_q   <= WIDTH'(dig_val);
              state_q <= StIntDig;
            end else if (is_nl) begin
              WbData  <= '0;
              WbValid <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StIntDig: begin
          if (xfer) begin
            if (is_digit) begin
              acc_q <= mac[WIDTH-1:0];
              if (|mac[WIDTH+3:WIDTH]) begin
                Overflow <= 1'b1;
              end
            end else if (is_nl) begin
              WbData  <= int_result;
              WbValid <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StChar: begin
          if (xfer) begin
            WbData  <= WIDTH'(InData);
            WbValid <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_reader.sv
// Directed self-checking bench for syscall_reader.
module tb_syscall_reader;

  logic        clk;
  logic        reset;
  logic        Syscall;
  logic [31:0] V0;
  logic        InValid;
  logic [7:0]  InData;
  logic        InReady;
  logic        StallReq;
  logic        WbValid;
  logic [31:0] WbData;
  logic        Overflow;
`ifdef SYSCALL_READER_ECHO_EN
  logic        EchoValid;
  logic [7:0]  EchoData;
  logic        EchoReady;
`endif

  int errors = 0;
  int checks = 0;

  syscall_reader dut (
    .clk       (clk),
    .reset     (reset),
    .Syscall   (Syscall),
    .V0        (V0),
    .InValid   (InValid),
    .InData    (InData),
    .InReady   (InReady),
    .StallReq  (StallReq),
    .WbValid   (WbValid),
    .WbData    (WbData),
`ifdef SYSCALL_READER_ECHO_EN
    .Overflow  (Overflow),
    .EchoValid (EchoValid),
    .EchoData  (EchoData),
    .EchoReady (EchoReady)
`else
    .Overflow  (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one syscall, feed the string as fast as InReady allows, capture the result.
  task automatic run_read(input logic [31:0] code, input string s, output logic [31:0] data,
                          output logic ovf, output int stalls, output bit got);
    int idx;
    bit take;
    idx    = 0;
    data   = '0;
    ovf    = 1'b0;
    stalls = 0;
    got    = 1'b0;
    Syscall = 1'b1;
    V0      = code;
    if (s.len() > 0) begin
      InValid = 1'b1;
      InData  = s[0];
    end else begin
      InValid = 1'b0;
    end
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      if (StallReq) stalls++;
      if (WbValid) begin
        got  = 1'b1;
        data = WbData;
        ovf  = Overflow;
      end
      take = InValid && InReady;
      step();
      if (take) idx++;
      if (got) Syscall = 1'b0;
      if (idx < s.len()) begin
        InValid = 1'b1;
        InData  = s[idx];
      end else begin
        InValid = 1'b0;
      end
    end
    Syscall = 1'b0;
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    Syscall = 1'b0;
    V0      = '0;
    InValid = 1'b0;
    InData  = '0;
`ifdef SYSCALL_READER_ECHO_EN
    EchoReady = 1'b1;
`endif
    #3;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready: got %b want 0", InReady); end
    checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallReq); end
    checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL reset_wbvalid: got %b want 0", WbValid); end
    checks++; if (WbData !== 32'h0) begin errors++; $display("FAIL reset_wbdata: got %h want 0", WbData); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_int_basic();
    logic [31:0] d; logic o; int st; bit g;
    run_read(32'd5, "123\n", d, o, st, g);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL int123_done: got %b want 1", g); end
    checks++; if (d !== 32'h0000007B) begin errors++; $display("FAIL int123_data: got %h want 0000007b", d); end
    checks++; if (st != 5) begin errors++; $display("FAIL int123_stall_cycles: got %0d want 5", st); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL int123_overflow: got %b want 0", o); end
    @(negedge clk);
    checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL int123_strobe_len: got %b want 0", WbValid); end
    checks++; if (WbData !== 32'h0000007B) begin errors++; $display("FAIL int123_hold: got %h want 0000007b", WbData); end
    step();
  endtask

  task automatic test_read_int_negative();
    logic [31:0] d; logic o; int st; bit g;
    run_read(32'd5, "  -45\n", d, o, st, g);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL neg45_done: got %b want 1", g); end
    checks++; if (d !== 32'hFFFFFFD3) begin errors++; $display("FAIL neg45_data: got %h want ffffffd3", d); end
    checks++; if (st != 7) begin errors++; $display("FAIL neg45_stall_cycles: got %0d want 7", st); end
    // junk before the number and a stray '-' between digits are both dropped
    run_read(32'd5, "a1-2\n", d, o, st, g);
    checks++; if (d !== 32'h0000000C || g !== 1'b1) begin errors++; $display("FAIL junk12_data: got %h want 0000000c", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic o; int st; bit g;
    run_read(32'd5, "4294967296\n", d, o, st, g);
    checks++; if (d !== 32'h0 || g !== 1'b1) begin errors++; $display("FAIL ovf_data: got %h want 0", d); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
    run_read(32'd5, "\n", d, o, st, g);
    checks++; if (d !== 32'h0 || g !== 1'b1) begin errors++; $display("FAIL nl_only_data: got %h want 0", d); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL nl_only_overflow: got %b want 0", o); end
    checks++; if (st != 2) begin errors++; $display("FAIL nl_only_stall_cycles: got %0d want 2", st); end
  endtask

  task automatic test_read_char_wait();
    Syscall = 1'b1;
    V0      = 32'd12;
    InValid = 1'b0;
    @(negedge clk);
    checks++; if (StallReq !== 1'b1 || InReady !== 1'b0) begin errors++; $display("FAIL char_trigger: got stall=%b ready=%b want 1 0", StallReq, InReady); end
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (InReady !== 1'b1 || StallReq !== 1'b1 || WbValid !== 1'b0) begin
        errors++;
        $display("FAIL char_wait%0d: got ready=%b stall=%b wbv=%b want 1 1 0", i, InReady, StallReq, WbValid);
      end
      step();
    end
    InValid = 1'b1;
    InData  = 8'h41;
    @(negedge clk);
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL char_xfer_ready: got %b want 1", InReady); end
    step();
    InValid = 1'b0;
    @(negedge clk);
    checks++; if (WbValid !== 1'b1) begin errors++; $display("FAIL char_wbvalid: got %b want 1", WbValid); end
    checks++; if (WbData !== 32'h00000041) begin errors++; $display("FAIL char_data: got %h want 00000041", WbData); end
    checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL char_done_stall: got %b want 0", StallReq); end
    step();
    Syscall = 1'b0;
    @(negedge clk);
    checks++; if (WbValid !== 1'b0 || StallReq !== 1'b0) begin errors++; $display("FAIL char_after: got wbv=%b stall=%b want 0 0", WbValid, StallReq); end
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; logic o; int st; bit g;
    Syscall = 1'b1;
    V0      = 32'd5;
    InValid = 1'b1;
    InData  = 8'h31;
    step();
    step();
    InData = 8'h32;
    step();
    InValid = 1'b0;
    #2;
    reset   = 1'b1;
    Syscall = 1'b0;
    #1;
    checks++; if (StallReq !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got stall=%b ready=%b want 0 0", StallReq, InReady); end
    checks++; if (WbData !== 32'h0) begin errors++; $display("FAIL midrst_wbdata: got %h want 0", WbData); end
    checks++; if (WbValid !== 1'b0 || Overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: got wbv=%b ovf=%b want 0 0", WbValid, Overflow); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (WbValid !== 1'b0 || StallReq !== 1'b0 || InReady !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle%0d: got wbv=%b stall=%b ready=%b want 0 0 0", i, WbValid, StallReq, InReady);
      end
    end
    step();
    run_read(32'd5, "7\n", d, o, st, g);
    checks++; if (d !== 32'h00000007 || g !== 1'b1) begin errors++; $display("FAIL midrst_reread: got %h want 00000007", d); end
  endtask

  task automatic test_ignored_and_back_to_back();
    logic [31:0] d; logic o; int st; bit g;
    Syscall = 1'b1;
    V0      = 32'd10;
    InValid = 1'b1;
    InData  = 8'h39;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (StallReq !== 1'b0 || InReady !== 1'b0 || WbValid !== 1'b0) begin
        errors++;
        $display("FAIL ignored%0d: got stall=%b ready=%b wbv=%b want 0 0 0", i, StallReq, InReady, WbValid);
      end
      step();
    end
    checks++; if (WbData !== 32'h00000007) begin errors++; $display("FAIL ignored_hold: got %h want 00000007", WbData); end
    Syscall = 1'b0;
    InValid = 1'b0;
    step();
    run_read(32'd12, "x", d, o, st, g);
    checks++; if (d !== 32'h00000078 || g !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h want 00000078", d); end
    checks++; if (st != 2) begin errors++; $display("FAIL b2b_first_stall: got %0d want 2", st); end
    run_read(32'd12, "z", d, o, st, g);
    checks++; if (d !== 32'h0000007A || g !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h want 0000007a", d); end
    checks++; if (st != 2) begin errors++; $display("FAIL b2b_second_stall: got %0d want 2", st); end
  endtask

  initial begin
    test_reset();
    test_read_int_basic();
    test_read_int_negative();
    test_overflow();
    test_read_char_wait();
    test_reset_mid_read();
    test_ignored_and_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syscall_reader.md
Name: syscall_reader

Overview:
- Input-side syscall responder; the receiving counterpart of the core's print path.
- Sits beside the syscall handler at writeback. Services read_int (v0=5) and read_char (v0=12) by consuming bytes from an external console with a valid/ready handshake.
- Holds the pipeline with a stall request while servicing a call, then returns the result for writing into $v0 ($2).

Parameters:
- WIDTH, 32, register/result width.
- CHAR_W, 8, console byte width.
- READ_INT_CODE, 5, v0 code that selects decimal integer read.
- READ_CHAR_CODE, 12, v0 code that selects single character read.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Syscall  in  1  syscall instruction present in the W stage (level).
- V0  in  WIDTH  current $v0 value (syscall code).
- InValid  in  1  console byte available.
- InData  in  CHAR_W  console byte (ASCII).
- InReady  out  1  unit accepts a byte this cycle.
- StallReq  out  1  freeze F/D/E/M/W until the syscall completes.
- WbValid  out  1  one-cycle strobe: write WbData into $v0.
- WbData  out  WIDTH  syscall result.
- Overflow  out  1  sticky for the last read_int: the magnitude exceeded WIDTH bits.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; InReady=0, StallReq=0, WbValid=0, WbData=0, Overflow=0.
  - The accumulator and sign are cleared.
  - A partial read in progress is discarded; no WbValid follows.
- States: IDLE, INT_LEAD, INT_DIG, CHAR, DONE.
- IDLE:
  - InReady=0.
  - If Syscall && V0==READ_INT_CODE, StallReq goes high combinationally in the same cycle. Next state INT_LEAD; acc=0, neg=0, Overflow=0.
  - If Syscall && V0==READ_CHAR_CODE, StallReq goes high combinationally. Next state CHAR.
  - Any other code: ignored, StallReq=0.
- A transfer occurs only when InValid && InReady. InReady=1 exactly in INT_LEAD, INT_DIG and CHAR. The unit never accepts a byte in IDLE or DONE.
- INT_LEAD:
  - ' ' (0x20) and '\t' are discarded.
  - '-' sets neg=1 and moves to INT_DIG.
  - A digit 0x30-0x39 sets acc=digit and moves to INT_DIG.
  - '\n' (0x0A) sets the result to 0 and moves to DONE.
  - Any other byte is discarded.
- INT_DIG:
  - A digit computes acc = acc*10 + digit, modulo 2^WIDTH. Overflow is set if the true product or sum exceeds 2^WIDTH-1.
  - '\n' sets result = neg ? -acc : acc (two's complement) and moves to DONE.
  - A later '-' or other non-digit is discarded.
- CHAR: the first byte accepted sets WbData = zero-extended byte and moves to DONE. This includes '\n'.
- DONE:
  - Lasts exactly one cycle: StallReq=0, WbValid=1, WbData holds the result.
  - The pipeline advances on that edge; the next state is IDLE.
  - WbData holds its value until the next DONE.
- StallReq is 1 in INT_LEAD, INT_DIG and CHAR, and in the IDLE trigger cycle.
- Latency: read_char completes in trigger + 1 + bytes-waited + 1 cycles. Minimum 3 cycles from Syscall to WbValid.
- Back-to-back syscalls: a new Syscall in the cycle after DONE is a fresh trigger.
- InValid held with InReady=0 leaves the byte pending; no loss and no duplication.

Optional Feature:
- Macro: SYSCALL_READER_ECHO_EN.
- When defined, the unit adds the following ports:
  - EchoValid (out, 1)
  - EchoData (out, CHAR_W)
  - EchoReady (in, 1)
- Every accepted byte, including discarded ones, is echoed. InReady is gated by EchoReady, so a byte is accepted only when echo can also accept it. EchoValid mirrors the transfer cycle.
- When undefined, these ports are absent and InReady is independent of echo.

Decomposition:
- Package syscall_pkg holds:
  - state enum
  - READ_INT_CODE / READ_CHAR_CODE defaults
  - ASCII constants: ASCII_NL, ASCII_SP, ASCII_TAB, ASCII_MINUS, ASCII_ZERO, ASCII_NINE
- One sub-module: ascii_digit_decode. Combinational; input byte; outputs is_digit and a 4-bit value. Instantiated once.

Test Plan:
- V0=5, Syscall=1, bytes "123\n" with InValid always high -> StallReq high for 5 cycles; WbValid one cycle; WbData=0x0000007B; Overflow=0.
- V0=5, bytes "  -45\n" -> WbData=0xFFFFFFD3; leading spaces consumed without effect.
- V0=12, InValid low for 4 cycles, then 'A' -> InReady high throughout the wait; WbData=0x00000041 one cycle after the transfer; StallReq deasserts in the DONE cycle.
- V0=5, bytes "4294967296\n" -> WbData=0x00000000, Overflow=1. V0=5, "\n" -> WbData=0, Overflow=0.
- Reset asserted mid read_int after "12" -> outputs zero immediately, state IDLE, no WbValid. A subsequent "7\n" read returns 7.
- V0=10 with Syscall=1 -> StallReq stays 0, InReady stays 0, no WbValid. A back-to-back read_char directly after DONE is serviced correctly.
